// File: rtl/kernel_loader.sv
// kernel_loader: buffers 16 3x3 kernels from a byte-serial stream and bursts them gap-free.
// Optional trailing checksum word: define KERNEL_LOADER_CHECKSUM_EN.
`default_nettype none

module kernel_loader #(
  parameter int COEF_WIDTH  = 8,
  parameter int NUM_KERNELS = 16
) (
  input  logic                    clk_i,
  input  logic                    nreset_i,
  input  logic                    load_start_i,
  input  logic                    coef_valid_i,
  input  logic [COEF_WIDTH-1:0]   coef_i,
  output logic                    coef_rdy_o,
  output logic [9*COEF_WIDTH-1:0] kernel_o,
  output logic                    kernel_valid_o,
  output logic [3:0]              kernel_idx_o,
  output logic                    load_busy_o,
  output logic                    load_done_o,
  output logic                    load_err_o
);

  localparam int NUM_COEF = NUM_KERNELS * 9;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_CHECK   = 3'd2,
    S_BURST   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                  state_q;
  logic [7:0]              cnt_q;
  logic [3:0]              idx_q;
  logic                    kvalid_q;
  logic                    done_q;
  logic [9*COEF_WIDTH-1:0] kernel_q;
  logic [COEF_WIDTH-1:0]   buf_q [NUM_COEF];

  logic                    store_d;
  logic                    last_d;
  logic [3:0]              rd_k_d;
  logic [7:0]              rd_base_d;
  logic [9*COEF_WIDTH-1:0] kernel_d;

  assign coef_rdy_o     = (state_q == S_COLLECT) || (state_q == S_CHECK);
  assign load_busy_o    = (state_q == S_COLLECT) || (state_q == S_CHECK) || (state_q == S_BURST);
  assign kernel_o       = kernel_q;
  assign kernel_valid_o = kvalid_q;
  assign kernel_idx_o   = idx_q;
  assign load_done_o    = done_q;

  // A restart pulse wins over a coincident coefficient, which is dropped.
  assign store_d = (state_q == S_COLLECT) && coef_valid_i && !load_start_i;
  assign last_d  = (cnt_q == 8'(NUM_COEF - 1));

  // Buffer holds no reset value; it only has meaning after a completed load.
  always_ff @(posedge clk_i) begin
    if (store_d) begin
      buf_q[cnt_q] <= coef_i;
    end
  end

  // Kernel loaded into the output register on the next edge: 0 on burst entry, else idx+1.
  assign rd_k_d    = (state_q == S_BURST) ? idx_q + 4'd1 : 4'd0;
  assign rd_base_d = {4'd0, rd_k_d} * 8'd9;

  always_comb begin
    kernel_d = '0;
    for (int e = 0; e < 9; e++) begin
      kernel_d[e*COEF_WIDTH +: COEF_WIDTH] = buf_q[rd_base_d + 8'(e)];
    end
  end

`ifdef KERNEL_LOADER_CHECKSUM_EN
  logic                  err_q;
  logic [COEF_WIDTH-1:0] sum_q;
  assign load_err_o = err_q;
`else
  assign load_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      kvalid_q <= 1'b0;
      done_q   <= 1'b0;
      kernel_q <= '0;
`ifdef KERNEL_LOADER_CHECKSUM_EN
      err_q    <= 1'b0;
      sum_q    <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_start_i) begin
            state_q <= S_COLLECT;
            cnt_q   <= '0;
`ifdef KERNEL_LOADER_CHECKSUM_EN
            err_q   <= 1'b0;
            sum_q   <= '0;
`endif
          end
        end
        S_COLLECT: begin
          if (load_start_i) begin
            cnt_q <= '0;
`ifdef KERNEL_LOADER_CHECKSUM_EN
            sum_q <= '0;
`endif
          end else if (coef_valid_i) begin
`ifdef KERNEL_LOADER_CHECKSUM_EN
            sum_q <= sum_q + coef_i;
`endif
            if (last_d) begin
              cnt_q    <= '0;
`ifdef KERNEL_LOADER_CHECKSUM_EN
              state_q  <= S_CHECK;
`else
              state_q  <= S_BURST;
              kvalid_q <= 1'b1;
              idx_q    <= '0;
              kernel_q <= kernel_d;
`endif
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
`ifdef KERNEL_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (load_start_i) begin
            state_q <= S_COLLECT;
            cnt_q   <= '0;
            sum_q   <= '0;
          end else if (coef_valid_i) begin
            if (coef_i == sum_q) begin
              state_q  <= S_BURST;
              kvalid_q <= 1'b1;
              idx_q    <= '0;
              kernel_q <= kernel_d;
            end else begin
              err_q   <= 1'b1;
              state_q <= S_IDLE;
            end
          end
        end
`endif
        S_BURST: begin
          if (idx_q == 4'(NUM_KERNELS - 1)) begin
            state_q  <= S_DONE;
            kvalid_q <= 1'b0;
            idx_q    <= '0;
            kernel_q <= '0;
            done_q   <= 1'b1;
          end else begin
            idx_q    <= idx_q + 4'd1;
            kernel_q <= kernel_d;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/kernel_loader.md
# kernel_loader

Collects the 16 convolution kernels of the CNN front end from an external byte-serial coefficient stream and bursts them into the kernel input port of the CNN top level. Each kernel is a 3x3 coefficient matrix. The CNN top level only captures kernels while its valid input is held high for consecutive cycles, and restarts its kernel count whenever valid drops. This block therefore buffers all 144 coefficients first, then drives exactly 16 back-to-back kernel-valid cycles with no gaps.

## Interface
- COEF_WIDTH, 8, bit width of one kernel coefficient
- NUM_KERNELS, 16, kernels per load; fixed at 16 for this design
- clk_i  input  1  system clock; all logic is on its rising edge
- nreset_i  input  1  reset, asynchronous and active-low
- load_start_i  input  1  pulse that begins a new kernel load
- coef_valid_i  input  1  coef_i holds a valid coefficient
- coef_i  input  COEF_WIDTH  signed coefficient (two's complement)
- coef_rdy_o  output  1  block accepts a coefficient this cycle
- kernel_o  output  9*COEF_WIDTH  kernel; element (r,c) occupies bits [(3r+c)*COEF_WIDTH +: COEF_WIDTH]
- kernel_valid_o  output  1  kernel_o is valid; connects to the CNN kernel valid input
- kernel_idx_o  output  4  index of the kernel currently on kernel_o
- load_busy_o  output  1  high in COLLECT, CHECK or BURST
- load_done_o  output  1  one-cycle pulse after a completed burst
- load_err_o  output  1  sticky checksum error flag

## Operation
- FSM states: IDLE, COLLECT, CHECK, BURST, DONE.
- IDLE
  - load_start_i moves the FSM to COLLECT.
  - The coefficient counter (0..143) and load_err_o are cleared.
- COLLECT
  - coef_rdy_o = 1.
  - A coefficient is accepted when coef_valid_i && coef_rdy_o.
  - Coefficients are stored in arrival order: kernel 0 element (0,0),(0,1),(0,2),(1,0)..(2,2), then kernel 1, and so on up to kernel 15.
  - After the 144th accept, the FSM goes to CHECK when the macro is defined, otherwise to BURST.
- CHECK: described under Configuration.
- BURST
  - Lasts exactly 16 cycles, k = 0..15.
  - In each cycle: kernel_valid_o = 1, kernel_o = stored kernel k, kernel_idx_o = k.
  - After k = 15 the FSM goes to DONE.
- DONE
  - load_done_o = 1 for one cycle, then the FSM returns to IDLE.
- Outside BURST, kernel_o = 0, kernel_idx_o = 0 and kernel_valid_o = 0.
- load_start_i during COLLECT or CHECK restarts the load: the counter is cleared and the FSM stays in or returns to COLLECT.
  - If load_start_i and an accepting coefficient coincide, the coefficient is discarded.
- load_start_i during BURST or DONE is ignored; the burst is never interrupted.
- The coefficient buffer is not reset. Its contents are only valid for a load that completes.

## Timing
- Reset values:
  - All outputs are 0.
  - FSM is in IDLE and counters are 0.
  - Reset asserted mid-COLLECT or mid-BURST aborts immediately; no further kernel_valid_o cycles occur.
- load_start_i sampled high at edge n gives coef_rdy_o = 1 from cycle n+1.
- Without the macro, the 144th accept at edge m gives kernel_valid_o high for cycles m+1..m+16 and load_done_o at cycle m+17.
- The macro adds the checksum accept cycle(s) between collection and burst.
- coef_valid_i may drop at any time during COLLECT; the stall length is unbounded and no timeout is applied.
- kernel_valid_o is registered; there is no combinational path from any input to it.

## Configuration
- Macro KERNEL_LOADER_CHECKSUM_EN.
- When defined:
  - CHECK state exists with coef_rdy_o = 1.
  - The next accepted word is compared with the sum of all 144 coefficients modulo 2^COEF_WIDTH, treating coefficients as unsigned.
  - On a match the FSM goes to BURST.
  - On a mismatch, load_err_o is set (it stays high until the next load_start_i), there is no burst and no load_done_o, and the FSM returns to IDLE.
- When not defined:
  - The CHECK state is absent and load_err_o is tied 0.
  - BURST follows the 144th coefficient directly.

## Test plan
- Basic load: reset, then load_start_i, then 144 coefficients with value = index mod 256, all with valid held high.
  - Required: 16 consecutive kernel_valid_o cycles.
  - Kernel 3 element (1,2) = 32 (3*9+5).
  - kernel_idx_o runs 0..15, then load_done_o pulses once.
- Stall: insert random 0-5 cycle gaps in coef_valid_i.
  - Required: stored data is identical to the basic load, and the burst is still gap-free 16 cycles.
- Restart: load_start_i after 50 coefficients, then 144 coefficients all 0x7F.
  - Required: every element of every kernel = 0x7F.
- Burst protection: load_start_i pulsed during BURST cycle 8.
  - Required: all 16 kernels are still emitted, then the FSM returns to IDLE.
- Reset mid-burst: nreset_i low at BURST cycle 5.
  - Required: kernel_valid_o = 0 in the same cycle and stays 0.
  - No load_done_o.
- Checksum (macro defined), 144 coefficients all 1:
  - Checksum 0x90 → burst occurs.
  - Checksum 0x91 → load_err_o = 1, no kernel_valid_o, and load_err_o clears on the next load_start_i.
